// File: rtl/ptg_pkg.sv
// Shared types and helpers for the pin pattern generator: mode encodings
// and the error-counter width with its saturating increment.
package ptg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  localparam int ERR_CNT_W = 16;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ptg_checker.sv
// Loopback checker: delays the expected pattern slice and its enable through
// a CHK_LAT-deep pipeline, then counts mismatches against the returned pins.
module ptg_checker
  import ptg_pkg::*;
#(
  parameter int CHK_W   = 16,
  parameter int CHK_LAT = 2
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 chk_en,
  input  logic [CHK_W-1:0]     exp_in,
  input  logic [CHK_W-1:0]     chk_in,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky
);

  logic [CHK_W-1:0]     exp_r [CHK_LAT];
  logic [CHK_LAT-1:0]   vld_r;
  logic                 mismatch_s;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic                 err_sticky_r;

  // Mismatch is only meaningful when the oldest pipeline stage is valid
  always_comb begin
    mismatch_s = 1'b0;
    if (vld_r[CHK_LAT-1]) begin
      mismatch_s = (chk_in != exp_r[CHK_LAT-1]);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Expected-value delay line; contents are don't-care while invalid
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHK_LAT; i++) exp_r[i] <= '0;
    end else begin
      exp_r[0] <= exp_in;
      for (int i = 1; i < CHK_LAT; i++) exp_r[i] <= exp_r[i-1];
    end
  end

  // Valid flags; a flush drops every in-flight compare including this cycle's enable
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else if (flush) begin
      vld_r <= '0;
    end else begin
      vld_r[0] <= chk_en;
      for (int i = 1; i < CHK_LAT; i++) vld_r[i] <= vld_r[i-1];
    end
  end

  // Saturating error count and sticky flag; flush wins over a same-cycle mismatch
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r    <= '0;
      err_sticky_r <= 1'b0;
    end else if (flush) begin
      err_cnt_r    <= '0;
      err_sticky_r <= 1'b0;
    end else if (mismatch_s) begin
      err_cnt_r    <= sat_inc(err_cnt_r);
      err_sticky_r <= 1'b1;
    end
  end

  assign err_cnt    = err_cnt_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: rtl/pin_pattern_gen.sv
// Board bring-up pin pattern generator: LFSR / walking-one pattern with
// run/step/hold control, seed loading, a divided clock and a loopback checker.
module pin_pattern_gen
  import ptg_pkg::*;
#(
  parameter int               WIDTH   = 54,
  parameter logic [WIDTH-1:0] TAPS    = 54'h30_0000_0003_0000,
  parameter logic [WIDTH-1:0] SEED    = 54'h1,
  parameter int               DIV     = 4,
  parameter int               CHK_W   = 16,
  parameter int               CHK_LAT = 2
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 step,
  input  logic                 load,
  input  logic [WIDTH-1:0]     seed_in,
  output logic [WIDTH-1:0]     pat,
  output logic                 div_clk,
  input  logic                 chk_en,
  input  logic [CHK_W-1:0]     chk_in,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky
);

  localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam int               HALF    = DIV / 2;
  localparam int               DIV_CW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_CW-1:0] CNT_MAX = DIV_CW'(HALF - 1);

  mode_e             mode_s;
  logic [WIDTH-1:0]  pat_r;
  logic [WIDTH-1:0]  pat_nxt_s;
  logic [WIDTH-1:0]  lfsr_nxt_s;
  logic [WIDTH-1:0]  walk_nxt_s;
  logic [WIDTH-1:0]  seed_fix_s;
  logic              walk_init_r;
  logic [DIV_CW-1:0] div_cnt_r;
  logic              div_clk_r;

  assign mode_s = mode_e'(mode);

  // Candidate next patterns; a zero seed would lock the LFSR, so it becomes 1
  always_comb begin
    lfsr_nxt_s = {pat_r[WIDTH-2:0], ^(pat_r & TAPS)};
    walk_nxt_s = {pat_r[WIDTH-2:0], pat_r[WIDTH-1]};
    if (seed_in == '0) begin
      seed_fix_s = ONE_C;
    end else begin
      seed_fix_s = seed_in;
    end
  end

  // Next-pattern select: load overrides whatever the mode would do
  always_comb begin
    pat_nxt_s = pat_r;
    if (load) begin
      pat_nxt_s = seed_fix_s;
    end else begin
      case (mode_s)
        MODE_HOLD: pat_nxt_s = pat_r;
        MODE_RUN:  pat_nxt_s = lfsr_nxt_s;
        MODE_STEP: pat_nxt_s = step ? lfsr_nxt_s : pat_r;
        MODE_WALK: pat_nxt_s = walk_init_r ? walk_nxt_s : ONE_C;
        default:   pat_nxt_s = pat_r;
      endcase
    end
  end

  // Pattern register; walk_init marks that the walking one has been seeded
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r       <= SEED;
      walk_init_r <= 1'b0;
    end else begin
      pat_r       <= pat_nxt_s;
      walk_init_r <= (mode_s == MODE_WALK);
    end
  end

  // Free-running half-period counter; div_clk flips on each wrap
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      div_clk_r <= 1'b0;
    end else if (div_cnt_r == CNT_MAX) begin
      div_cnt_r <= '0;
      div_clk_r <= ~div_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_CW'(1);
    end
  end

  ptg_checker #(
    .CHK_W   (CHK_W),
    .CHK_LAT (CHK_LAT)
  ) u_checker (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .flush      (load),
    .chk_en     (chk_en),
    .exp_in     (pat_r[CHK_W-1:0]),
    .chk_in     (chk_in),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  assign pat     = pat_r;
  assign div_clk = div_clk_r;

endmodule

// File: tb/tb_pin_pattern_gen.sv
// Directed self-checking bench for pin_pattern_gen with default parameters.
module tb_pin_pattern_gen;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        step;
  logic        load;
  logic [53:0] seed_in;
  logic [53:0] pat;
  logic        div_clk;
  logic        chk_en;
  logic [15:0] chk_in;
  logic [15:0] err_cnt;
  logic        err_sticky;

  logic [15:0] d1 = 16'h0;
  logic [15:0] d2 = 16'h0;
  logic [15:0] inv_mask;

  int n_assert = 0;
  int n_fail   = 0;

  pin_pattern_gen dut (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .mode       (mode),
    .step       (step),
    .load       (load),
    .seed_in    (seed_in),
    .pat        (pat),
    .div_clk    (div_clk),
    .chk_en     (chk_en),
    .chk_in     (chk_in),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always #5 fclk = ~fclk;

  // Loopback model: pins return the low pattern bits two cycles late
  always @(posedge fclk) begin
    d1 <= pat[15:0];
    d2 <= d1;
  end
  assign chk_in = d2 ^ inv_mask;

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [53:0] top_bit;
    top_bit  = 54'h1 << 53;
    rst_n    = 1'b0;
    mode     = 2'b01;
    step     = 1'b0;
    load     = 1'b0;
    seed_in  = 54'h0;
    chk_en   = 1'b0;
    inv_mask = 16'h0;
    tick();
    tick();
    chk("rst_pat", 64'(pat), 64'h1);
    chk("rst_div", 64'(div_clk), 64'h0);
    chk("rst_err", 64'(err_cnt), 64'h0);
    chk("rst_sticky", 64'(err_sticky), 64'h0);

    // RUN from reset, with divider observed over the same cycles
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("div_seq", 64'(div_clk), 64'((i / 2) % 2));
      if (i == 1)  chk("run_1", 64'(pat), 64'h2);
      if (i == 16) chk("run_16", 64'(pat), 64'h10000);
      if (i == 17) chk("run_17", 64'(pat), 64'h20001);
    end

    // WALK entered from RUN
    mode = 2'b11;
    tick();
    chk("walk_first", 64'(pat), 64'h1);
    repeat (53) tick();
    chk("walk_53", 64'(pat), 64'(top_bit));
    tick();
    chk("walk_wrap", 64'(pat), 64'h1);
    tick();
    tick();
    chk("walk_4", 64'(pat), 64'h4);
    mode = 2'b00;
    repeat (3) tick();
    chk("hold", 64'(pat), 64'h4);
    mode = 2'b11;
    tick();
    chk("walk_restart", 64'(pat), 64'h1);
    tick();
    chk("walk_again", 64'(pat), 64'h2);

    // Seed loading and stepping
    mode    = 2'b01;
    load    = 1'b1;
    seed_in = 54'h0;
    tick();
    chk("load_zero", 64'(pat), 64'h1);
    mode    = 2'b10;
    seed_in = 54'h5;
    tick();
    chk("load_step", 64'(pat), 64'h5);
    load = 1'b0;
    tick();
    tick();
    chk("step_idle", 64'(pat), 64'h5);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_pulse", 64'(pat), 64'hA);
    tick();
    chk("step_after", 64'(pat), 64'hA);
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    chk("step_held", 64'(pat), 64'h28);

    // Loopback checking in RUN
    mode   = 2'b01;
    chk_en = 1'b1;
    repeat (6) tick();
    chk("loop_clean", 64'(err_cnt), 64'h0);
    chk("loop_clean_sticky", 64'(err_sticky), 64'h0);
    inv_mask = 16'h0008;
    repeat (5) tick();
    inv_mask = 16'h0;
    chk("loop_err5", 64'(err_cnt), 64'h5);
    chk("loop_sticky", 64'(err_sticky), 64'h1);
    repeat (3) tick();
    chk("loop_err5_hold", 64'(err_cnt), 64'h5);

    // load flushes: mismatches in the load cycle and the two after are not counted
    inv_mask = 16'h0008;
    load     = 1'b1;
    seed_in  = 54'h7;
    tick();
    load = 1'b0;
    chk("flush_err", 64'(err_cnt), 64'h0);
    chk("flush_sticky", 64'(err_sticky), 64'h0);
    chk("flush_pat", 64'(pat), 64'h7);
    tick();
    tick();
    inv_mask = 16'h0;
    chk("flush_gap", 64'(err_cnt), 64'h0);
    repeat (3) tick();
    chk("flush_resume", 64'(err_cnt), 64'h0);
    inv_mask = 16'h0001;
    tick();
    inv_mask = 16'h0;
    chk("resume_count", 64'(err_cnt), 64'h1);

    // Saturation
    inv_mask = 16'hFFFF;
    repeat (65600) tick();
    chk("sat_cnt", 64'(err_cnt), 64'hFFFF);
    chk("sat_sticky", 64'(err_sticky), 64'h1);
    inv_mask = 16'h0;

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pat", 64'(pat), 64'h1);
    chk("mid_rst_err", 64'(err_cnt), 64'h0);
    chk("mid_rst_sticky", 64'(err_sticky), 64'h0);
    chk("mid_rst_div", 64'(div_clk), 64'h0);
    chk_en = 1'b0;
    rst_n  = 1'b1;
    tick();
    tick();
    chk("div_rise", 64'(div_clk), 64'h1);
    tick();
    chk("div_high", 64'(div_clk), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("div_async_rst", 64'(div_clk), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
